// File: rtl/block_sync_ctrl.sv
// Supervisor for N_LANES block-sync FSMs: distributes configuration, gates per-lane
// signal_ok, detects all-lane lock and restarts the search on a lock timeout.
module block_sync_ctrl #(
   parameter int N_LANES        = 20,
   parameter int NB_WINDOW_CNT  = 11,
   parameter int NB_INVALID_CNT = 3,
   parameter int NB_TIMEOUT     = 16
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_enable,
   input  logic                      i_valid,
   input  logic                      i_signal_ok,
   input  logic                      i_start,
   input  logic [N_LANES-1:0]        i_block_lock,
   input  logic [NB_WINDOW_CNT-1:0]  i_unlocked_limit_cfg,
   input  logic [NB_WINDOW_CNT-1:0]  i_locked_limit_cfg,
   input  logic [NB_INVALID_CNT-1:0] i_invalid_limit_cfg,
   input  logic [NB_TIMEOUT-1:0]     i_lock_timeout,
   output logic [N_LANES-1:0]        o_lane_signal_ok,
   output logic [NB_WINDOW_CNT-1:0]  o_unlocked_timer_limit,
   output logic [NB_WINDOW_CNT-1:0]  o_locked_timer_limit,
   output logic [NB_INVALID_CNT-1:0] o_sh_invalid_limit,
   output logic                      o_all_lock,
   output logic [2:0]                o_state,
   output logic [7:0]                o_retry_count
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CONFIG  = 3'd1;
   localparam logic [2:0] ST_SEARCH  = 3'd2;
   localparam logic [2:0] ST_LOCKED  = 3'd3;
   localparam logic [2:0] ST_RESTART = 3'd4;

   logic [2:0]                state_q, state_d;
   logic [NB_TIMEOUT-1:0]     tmo_q, tmo_d;
   logic [1:0]                hold_q, hold_d;
   logic [N_LANES-1:0]        mask_q, mask_d;
   logic [N_LANES-1:0]        lane_ok_q, lane_ok_d;
   logic [NB_WINDOW_CNT-1:0]  unl_q, unl_d;
   logic [NB_WINDOW_CNT-1:0]  lck_q, lck_d;
   logic [NB_INVALID_CNT-1:0] inv_q, inv_d;
   logic                      all_lock_q, all_lock_d;
   logic [7:0]                retry_q, retry_d;
   logic                      all_locked_s;
   logic                      timeout_s;
   logic                      restart_req_s;

   assign all_locked_s  = &i_block_lock;
   assign timeout_s     = (i_lock_timeout != {NB_TIMEOUT{1'b0}}) && (tmo_q == i_lock_timeout);
   assign restart_req_s = i_signal_ok && i_start && (state_q != ST_IDLE);

   // Next-state selection: signal loss, then restart request, then per-state rules.
   always_comb begin
      state_d = state_q;
      if (!i_signal_ok) begin
         state_d = ST_IDLE;
      end else if (restart_req_s) begin
         state_d = ST_CONFIG;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_enable) state_d = ST_CONFIG;
               else          state_d = ST_IDLE;
            end
            ST_CONFIG: state_d = ST_SEARCH;
            ST_SEARCH: begin
               if (all_locked_s)   state_d = ST_LOCKED;
               else if (timeout_s) state_d = ST_RESTART;
               else                state_d = ST_SEARCH;
            end
            ST_LOCKED: begin
               if (!all_locked_s) state_d = ST_SEARCH;
               else               state_d = ST_LOCKED;
            end
            ST_RESTART: begin
               if (hold_q == 2'd3) state_d = ST_SEARCH;
               else                state_d = ST_RESTART;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Counters, lock mask, latched limits and output values, all keyed on the next state
   // so every output moves on the same edge as the transition that causes it.
   always_comb begin
      tmo_d   = tmo_q;
      hold_d  = 2'd0;
      mask_d  = mask_q;
      unl_d   = unl_q;
      lck_d   = lck_q;
      inv_d   = inv_q;
      retry_d = retry_q;

      // Timeout counter is only meaningful while staying in SEARCH; anything else restarts it.
      if ((state_d != ST_SEARCH) || (state_q != ST_SEARCH)) begin
         tmo_d = {NB_TIMEOUT{1'b0}};
      end else if (i_enable && i_valid) begin
         tmo_d = tmo_q + NB_TIMEOUT'(1);
      end else begin
         tmo_d = tmo_q;
      end

      if ((state_q == ST_RESTART) && (state_d == ST_RESTART)) begin
         hold_d = hold_q + 2'd1;
      end else begin
         hold_d = 2'd0;
      end

      if ((state_d == ST_RESTART) && (state_q != ST_RESTART)) begin
         mask_d = i_block_lock;
      end else begin
         mask_d = mask_q;
      end

      if ((state_q == ST_CONFIG) && (state_d == ST_SEARCH)) begin
         unl_d = i_unlocked_limit_cfg;
         lck_d = i_locked_limit_cfg;
         inv_d = i_invalid_limit_cfg;
      end else begin
         unl_d = unl_q;
         lck_d = lck_q;
         inv_d = inv_q;
      end

      if (restart_req_s) begin
         retry_d = 8'd0;
      end else if ((state_d == ST_RESTART) && (state_q != ST_RESTART) && (retry_q != 8'hFF)) begin
         retry_d = retry_q + 8'd1;
      end else begin
         retry_d = retry_q;
      end

      case (state_d)
         ST_SEARCH:  lane_ok_d = {N_LANES{1'b1}};
         ST_LOCKED:  lane_ok_d = {N_LANES{1'b1}};
         ST_RESTART: lane_ok_d = mask_d;
         default:    lane_ok_d = {N_LANES{1'b0}};
      endcase

      all_lock_d = (state_d == ST_LOCKED);
   end

   // State and output registers.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         tmo_q      <= {NB_TIMEOUT{1'b0}};
         hold_q     <= 2'd0;
         mask_q     <= {N_LANES{1'b0}};
         lane_ok_q  <= {N_LANES{1'b0}};
         unl_q      <= {NB_WINDOW_CNT{1'b0}};
         lck_q      <= {NB_WINDOW_CNT{1'b0}};
         inv_q      <= {NB_INVALID_CNT{1'b0}};
         all_lock_q <= 1'b0;
         retry_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         hold_q     <= hold_d;
         mask_q     <= mask_d;
         lane_ok_q  <= lane_ok_d;
         unl_q      <= unl_d;
         lck_q      <= lck_d;
         inv_q      <= inv_d;
         all_lock_q <= all_lock_d;
         retry_q    <= retry_d;
      end
   end

   assign o_state                = state_q;
   assign o_lane_signal_ok       = lane_ok_q;
   assign o_unlocked_timer_limit = unl_q;
   assign o_locked_timer_limit   = lck_q;
   assign o_sh_invalid_limit     = inv_q;
   assign o_all_lock             = all_lock_q;
   assign o_retry_count          = retry_q;

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Directed scoreboard bench for block_sync_ctrl with four lanes.
module tb_block_sync_ctrl;

   localparam int NL = 4;

   logic        clk;
   logic        rst_n;
   logic        en, vld, sig_ok, start;
   logic [NL-1:0] blk_lock;
   logic [10:0] unl_cfg, lck_cfg;
   logic [2:0]  inv_cfg;
   logic [15:0] tmo;
   logic [NL-1:0] lane_ok;
   logic [10:0] unl_lim, lck_lim;
   logic [2:0]  inv_lim;
   logic        all_lock;
   logic [2:0]  state;
   logic [7:0]  retry;

   int total = 0;
   int bad   = 0;
   int exp_retry;

   typedef struct {
      int          sel;
      logic [31:0] val;
      string       tag;
   } exp_t;
   exp_t sb[$];

   block_sync_ctrl #(.N_LANES(NL)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld),
      .i_signal_ok(sig_ok), .i_start(start), .i_block_lock(blk_lock),
      .i_unlocked_limit_cfg(unl_cfg), .i_locked_limit_cfg(lck_cfg),
      .i_invalid_limit_cfg(inv_cfg), .i_lock_timeout(tmo),
      .o_lane_signal_ok(lane_ok), .o_unlocked_timer_limit(unl_lim),
      .o_locked_timer_limit(lck_lim), .o_sh_invalid_limit(inv_lim),
      .o_all_lock(all_lock), .o_state(state), .o_retry_count(retry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return {29'd0, state};
         1:       return {28'd0, lane_ok};
         2:       return {21'd0, unl_lim};
         3:       return {21'd0, lck_lim};
         4:       return {29'd0, inv_lim};
         5:       return {31'd0, all_lock};
         default: return {24'd0, retry};
      endcase
   endfunction

   task automatic push_exp(input int sel, input logic [31:0] val, input string tag);
      exp_t e;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         total++;
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_now();
   endtask

   task automatic push_reset_vals(input string tag);
      push_exp(0, 32'd0, {tag, "_state"});
      push_exp(1, 32'd0, {tag, "_lane_ok"});
      push_exp(2, 32'd0, {tag, "_unl"});
      push_exp(3, 32'd0, {tag, "_lck"});
      push_exp(4, 32'd0, {tag, "_inv"});
      push_exp(5, 32'd0, {tag, "_all_lock"});
      push_exp(6, 32'd0, {tag, "_retry"});
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; vld = 1'b0; sig_ok = 1'b0; start = 1'b0;
      blk_lock = 4'h0; unl_cfg = 11'd0; lck_cfg = 11'd0; inv_cfg = 3'd0; tmo = 16'd0;
      @(posedge clk); @(posedge clk); #1;
      push_reset_vals("reset");
      check_now();

      // Bring-up
      rst_n = 1'b1; sig_ok = 1'b1; en = 1'b1; vld = 1'b1;
      unl_cfg = 11'd64; lck_cfg = 11'd1024; inv_cfg = 3'd6;
      push_exp(0, 32'd1, "bringup_config"); push_exp(1, 32'd0, "bringup_cfg_lane");
      push_exp(2, 32'd0, "limit_not_yet");
      tick();
      push_exp(0, 32'd2, "bringup_search"); push_exp(1, 32'hF, "search_lane");
      push_exp(2, 32'd64, "unl_lim"); push_exp(3, 32'd1024, "lck_lim");
      push_exp(4, 32'd6, "inv_lim"); push_exp(6, 32'd0, "retry_init");
      tick();

      // Lock, cfg change ignored outside CONFIG, then a lane drop
      unl_cfg = 11'd100; lck_cfg = 11'd200; inv_cfg = 3'd3; blk_lock = 4'hF;
      push_exp(0, 32'd3, "lock_state"); push_exp(5, 32'd1, "all_lock_set");
      push_exp(2, 32'd64, "cfg_ignored");
      tick();
      blk_lock = 4'b1011;
      push_exp(0, 32'd2, "drop_state"); push_exp(5, 32'd0, "all_lock_clr");
      push_exp(6, 32'd0, "drop_retry");
      tick();

      // Timeout: 8 valid cycles, then a 4-clock RESTART with the lock mask
      tmo = 16'd8;
      for (int i = 0; i < 8; i++) begin
         push_exp(0, 32'd2, "tmo_wait");
         tick();
      end
      push_exp(0, 32'd4, "tmo_restart"); push_exp(1, 32'hB, "restart_mask");
      push_exp(6, 32'd1, "retry_one");
      tick();
      for (int i = 0; i < 3; i++) begin
         push_exp(0, 32'd4, "restart_hold"); push_exp(1, 32'hB, "restart_mask_hold");
         tick();
      end
      push_exp(0, 32'd2, "restart_exit"); push_exp(1, 32'hF, "restart_exit_lane");
      tick();

      // Enable low freezes the timeout counter
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_exp(0, 32'd2, "en_hold");
         tick();
      end
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_exp(0, 32'd2, "en_resume_wait");
         tick();
      end
      push_exp(0, 32'd4, "en_restart"); push_exp(6, 32'd2, "retry_two");
      tick();
      for (int i = 0; i < 3; i++) tick();
      push_exp(0, 32'd2, "en_restart_exit");
      tick();

      // All-locked on the timeout cycle wins
      for (int i = 0; i < 8; i++) begin
         push_exp(0, 32'd2, "simul_wait");
         tick();
      end
      blk_lock = 4'hF;
      push_exp(0, 32'd3, "simul_locked"); push_exp(6, 32'd2, "simul_retry");
      tick();
      blk_lock = 4'b1011;
      push_exp(0, 32'd2, "simul_drop");
      tick();

      // Saturation over 300 timeouts
      tmo = 16'd1;
      exp_retry = 2;
      for (int k = 0; k < 300; k++) begin
         tick();
         exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
         push_exp(0, 32'd4, "sat_restart"); push_exp(6, 32'(exp_retry), "sat_retry");
         tick();
         for (int i = 0; i < 3; i++) tick();
         push_exp(0, 32'd2, "sat_back");
         tick();
      end
      push_exp(6, 32'd255, "retry_saturated");
      check_now();

      // Signal loss mid-RESTART
      tick();
      push_exp(0, 32'd4, "ovr_restart");
      tick();
      sig_ok = 1'b0;
      push_exp(0, 32'd0, "ovr_idle"); push_exp(1, 32'd0, "ovr_lane");
      push_exp(6, 32'd255, "ovr_retry_kept");
      tick();
      sig_ok = 1'b1;
      push_exp(0, 32'd1, "reconfig");
      tick();
      push_exp(0, 32'd2, "reconfig_search"); push_exp(2, 32'd100, "reconfig_unl");
      push_exp(3, 32'd200, "reconfig_lck"); push_exp(4, 32'd3, "reconfig_inv");
      tick();

      // Timeout disabled
      tmo = 16'd0;
      for (int i = 0; i < 40; i++) begin
         push_exp(0, 32'd2, "no_timeout");
         tick();
      end
      blk_lock = 4'hF;
      push_exp(0, 32'd3, "relock");
      tick();

      // Start from LOCKED
      start = 1'b1; unl_cfg = 11'd300; lck_cfg = 11'd500; inv_cfg = 3'd5;
      push_exp(0, 32'd1, "start_config"); push_exp(6, 32'd0, "start_retry_clr");
      push_exp(5, 32'd0, "start_all_lock"); push_exp(1, 32'd0, "start_lane");
      push_exp(2, 32'd100, "start_unl_old");
      tick();
      start = 1'b0;
      push_exp(0, 32'd2, "start_search"); push_exp(2, 32'd300, "start_unl");
      push_exp(3, 32'd500, "start_lck"); push_exp(4, 32'd5, "start_inv");
      tick();
      push_exp(0, 32'd3, "start_relock"); push_exp(5, 32'd1, "start_relock_all");
      tick();

      // Asynchronous reset between edges
      rst_n = 1'b0;
      #1;
      push_reset_vals("async_rst");
      check_now();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/block_sync_ctrl.md
BLOCK_SYNC_CTRL -- requirements
Module: block_sync_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_LANES, 20, number of per-lane block-sync instances supervised.
- NB_WINDOW_CNT, 11, width of the sync-header window limits.
- NB_INVALID_CNT, 3, width of the invalid sync-header limit.
- NB_TIMEOUT, 16, width of the lock timeout and its counter.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clock, in, 1, single clock.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_enable, in, 1, global enable.
- i_valid, in, 1, datapath valid qualifier.
- i_signal_ok, in, 1, PMA signal good.
- i_start, in, 1, pulse that re-applies configuration and restarts the search.
- i_block_lock, in, N_LANES, per-lane lock from the block-sync FSMs.
- i_unlocked_limit_cfg, in, NB_WINDOW_CNT, configured unlocked-state window.
- i_locked_limit_cfg, in, NB_WINDOW_CNT, configured locked-state window.
- i_invalid_limit_cfg, in, NB_INVALID_CNT, configured invalid sync-header limit.
- i_lock_timeout, in, NB_TIMEOUT, search timeout in valid cycles; 0 = timeout disabled.
- o_lane_signal_ok, out, N_LANES, per-lane signal_ok driven to the lane FSMs; 0 holds a lane in reset.
- o_unlocked_timer_limit, out, NB_WINDOW_CNT, latched copy of the unlocked window.
- o_locked_timer_limit, out, NB_WINDOW_CNT, latched copy of the locked window.
- o_sh_invalid_limit, out, NB_INVALID_CNT, latched copy of the invalid limit.
- o_all_lock, out, 1, all lanes locked.
- o_state, out, 3, current FSM state.
- o_retry_count, out, 8, saturating count of restarts.
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE=0, CONFIG=1, SEARCH=2, LOCKED=3, RESTART=4, and o_state SHALL equal the registered state.
REQ-005 Every output SHALL be registered and SHALL change on the same clock edge as the state transition that causes the change.
REQ-006 Transition priority SHALL be, highest first: i_signal_ok=0 -> IDLE; i_start=1 -> CONFIG, from any state other than IDLE; then the per-state rules below.
REQ-007 IDLE SHALL go to CONFIG when i_signal_ok=1 and i_enable=1, and SHALL drive o_lane_signal_ok=0 on all lanes.
REQ-008 CONFIG SHALL last exactly one clock:
- latch the three *_cfg inputs into the o_*_limit outputs;
- drive o_lane_signal_ok=0 on all lanes;
- clear o_retry_count when entered via i_start;
- go to SEARCH.
REQ-009 The o_*_limit outputs SHALL change only on the CONFIG-exit edge; a *_cfg change in any other state SHALL have no effect.
REQ-010 SEARCH SHALL drive o_lane_signal_ok all 1.
REQ-011 A timeout counter SHALL be cleared on entry to SEARCH and SHALL increment on each clock with i_enable && i_valid.
REQ-012 SEARCH exits:
- &i_block_lock=1 -> LOCKED;
- otherwise, counter == i_lock_timeout with i_lock_timeout != 0 -> RESTART;
- all-locked SHALL win over a timeout in the same cycle;
- i_lock_timeout=0 SHALL never time out.
REQ-013 LOCKED SHALL drive o_all_lock=1 and o_lane_signal_ok all 1.
REQ-014 LOCKED SHALL go to SEARCH, with counter cleared and o_retry_count unchanged, on the first clock where any i_block_lock bit is 0.
REQ-015 On entry to RESTART the block SHALL capture the lock mask = i_block_lock sampled on the entry edge, and SHALL increment o_retry_count, saturating at 255.
REQ-016 In RESTART the block SHALL drive o_lane_signal_ok = captured mask (locked lanes kept, unlocked lanes reset) for exactly 4 clocks, independent of i_valid, then go to SEARCH.
REQ-017 o_all_lock SHALL be 1 only in LOCKED; it SHALL assert one clock after all-locked is sampled in SEARCH and deassert one clock after a lane drop is sampled.
REQ-018 i_signal_ok=0 SHALL force the IDLE outputs on the next edge, mid-RESTART or mid-SEARCH, and SHALL abandon the hold counter and the timeout counter.
REQ-019 With i_enable=0, the timeout counter SHALL hold; transitions not gated by the counter SHALL still occur.

Reset
REQ-020 While i_reset_n=0 the block SHALL hold these values:
- state IDLE;
- o_lane_signal_ok=0;
- o_unlocked_timer_limit=0, o_locked_timer_limit=0, o_sh_invalid_limit=0;
- o_all_lock=0;
- o_retry_count=0;
- both counters=0 and captured mask=0.
REQ-021 Reset assertion SHALL take effect asynchronously; deassertion SHALL be synchronised externally.

Verification
Bench setup for all scenarios: N_LANES=4.
REQ-022 Bring-up: release reset, i_signal_ok=1, i_enable=1, cfg=(64,1024,6) -> o_state 0->1->2; limits read 64/1024/6 after CONFIG; o_lane_signal_ok=4'hF from SEARCH.
REQ-023 Lock: i_block_lock=4'hF in SEARCH -> o_all_lock=1 one clock later; drop bit 2 -> o_all_lock=0 and o_state=2 next clock; o_retry_count=0.
REQ-024 Timeout: i_lock_timeout=8, i_valid always 1, i_block_lock=4'b1011 -> RESTART after 8 valid cycles; o_lane_signal_ok=4'b1011 for 4 clocks; o_retry_count=1; back to SEARCH.
REQ-025 Simultaneous and saturation: all-locked on the timeout cycle -> LOCKED, not RESTART; 300 timeouts -> o_retry_count=255; i_lock_timeout=0 -> never RESTART.
REQ-026 Override: i_signal_ok=0 during RESTART -> IDLE, o_lane_signal_ok=0 next clock; i_start in LOCKED -> CONFIG, o_retry_count=0, new cfg latched.
REQ-027 Async reset mid-LOCKED: outputs return to reset values without a clock edge.
